sl_fifo_scheduler: RTL and testbench
====================================

// Module: sl_fifo_scheduler
// PURPOSE
//  Core-clock sequencer on the far side of the APB<->core async FIFO pair. Pops 34-bit
//  {modifier[1:0],data[31:0]} commands and dispatches them: config/channel register updates
//  and serial-line TX words. Arbitrates three sources into the response FIFO toward APB:
//  RX words, config/channel echoes and status updates.
// PARAMETERS
//  CONFIG_W    16    width of config_out; echo carries it in data[CONFIG_W-1:0]
//  CHANNEL_W   2     width of channel_out
//  TX_TIMEOUT  1024  cycles tx_valid may wait for tx_ready before abort; 0 = never abort
//  Modifier codes (fixed): 0 CONFIG, 1 DATA, 2 STATUS, 3 CHANNEL
// PORTS
//  clk            in   1          core clock
//  rst            in   1          synchronous, active-high reset
//  cmd_fifo_empty in   1          command FIFO empty
//  cmd_fifo_data  in   34         command FIFO head word; valid while !empty (first-word fall-through)
//  cmd_fifo_inc   out  1          1-cycle pop strobe
//  rsp_fifo_full  in   1          response FIFO full
//  rsp_fifo_data  out  34         response word
//  rsp_fifo_inc   out  1          1-cycle push strobe
//  tx_data        out  32         word to SL transmitter
//  tx_valid       out  1          tx_data valid; held until tx_ready or timeout
//  tx_ready       in   1          transmitter accepts word when tx_valid&tx_ready
//  rx_data        in   32         received SL word
//  rx_strobe      in   1          1-cycle: rx_data valid; no backpressure
//  sl_status      in   5          live transceiver flags
//  config_out     out  CONFIG_W   current config
//  channel_out    out  CHANNEL_W  current channel select
//  busy           out  1          command FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rx_pend, echo_pend, sticky flags, last_status = 0.
//   Reset mid-operation discards any popped, unexecuted command and any pending RX word.
//  Command FSM:
//   IDLE:   !cmd_fifo_empty -> latch cmd_fifo_data into cmd_r, cmd_fifo_inc=1 for 1 cycle, ->DECODE.
//   DECODE: mod 0: config_out<=cmd_r[CONFIG_W-1:0], echo_pend<=1, ->ECHO.
//           mod 3: channel_out<=cmd_r[CHANNEL_W-1:0], echo_pend<=1, ->ECHO.
//           mod 1: tx_data<=cmd_r[31:0], tx_valid<=1, timer<=0, ->TX.
//           mod 2: illegal from APB; cmd_err<=1 (sticky), ->IDLE.
//   TX:     tx_ready -> tx_valid<=0, ->IDLE. Else timer++; timer==TX_TIMEOUT-1 (TX_TIMEOUT!=0)
//           -> tx_valid<=0, tx_tmo<=1 (sticky), ->IDLE.
//   ECHO:   echo granted -> echo_pend<=0, ->IDLE.
//   Min command spacing 3 cycles (IDLE,DECODE,exec); at most one pop per command.
//  RX capture: rx_strobe & !rx_pend -> rx_buf<=rx_data, rx_pend<=1. rx_strobe & rx_pend & no RX
//   grant this cycle -> word dropped, rx_ovr<=1 (sticky). Same-cycle RX grant -> new word accepted.
//  Status word: stat = {sl_status[4:0], tx_tmo, rx_ovr, cmd_err}; status request when stat != last_status.
//  Response arbiter (fixed priority RX > ECHO > STATUS):
//   grant only if !rsp_fifo_full & !rsp_fifo_inc (max one push per 2 cycles; full flag may lag one cycle).
//   Grant registers: rsp_fifo_inc=1 next cycle with
//   RX {2'd1,rx_buf}; ECHO {2'd0, config zero-ext} or {2'd3, channel zero-ext} by cmd_r mod;
//   STATUS {2'd2, 24'd0, stat}.
//   rsp_fifo_data returns to 0 when rsp_fifo_inc is 0.
//   STATUS grant: last_status<=stat; sticky bits set in the pushed value clear same edge
//   (a set-during-push event stays set). Clear causes a follow-up status push.
//   Full response FIFO: requests wait; RX overrun accounting continues.
// TESTING
//  1 reset, push {2'd0,32'h0000_A5C3} -> config_out=16'hA5C3 two cycles after pop; rsp word
//    34'h0_0000_A5C3 pushed once.
//  2 {2'd1,32'hDEAD_BEEF}, tx_ready low 5 cycles then high -> tx_data=DEADBEEF held 6 cycles,
//    tx_valid drops cycle after handshake, no rsp push.
//  3 TX_TIMEOUT=8, tx_ready stuck 0 -> tx_valid low after 8 cycles; status push 34'h2_0000_0004
//    then 34'h2_0000_0000.
//  4 rx_strobe twice 1 cycle apart, rsp_fifo_full=1 -> 2nd dropped; release full -> RX word 1,
//    then status with rx_ovr=1 (bit1).
//  5 same cycle: RX pending, echo pending, sl_status=5'h01 -> pushes in order RX, ECHO, STATUS
//    34'h2_0000_0008, on alternate cycles.
//  6 {2'd2,x} command -> cmd_err status push 34'h2_0000_0001; rst asserted while in TX
//    -> all outputs 0 next edge.

Source files
------------

// File: rtl/sl_fifo_scheduler.sv
// Core-clock command sequencer: pops APB commands, drives config/channel/TX,
// and arbitrates RX words, echoes and status updates into the response FIFO.
module sl_fifo_scheduler #(
    parameter int CONFIG_W   = 16,
    parameter int CHANNEL_W  = 2,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_fifo_empty,
    input  logic [33:0]          cmd_fifo_data,
    output logic                 cmd_fifo_inc,
    input  logic                 rsp_fifo_full,
    output logic [33:0]          rsp_fifo_data,
    output logic                 rsp_fifo_inc,
    output logic [31:0]          tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [31:0]          rx_data,
    input  logic                 rx_strobe,
    input  logic [4:0]           sl_status,
    output logic [CONFIG_W-1:0]  config_out,
    output logic [CHANNEL_W-1:0] channel_out,
    output logic                 busy
);

    localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, DECODE, TX, ECHO} state_t;
    typedef enum logic [1:0] {
        MOD_CONFIG  = 2'd0,
        MOD_DATA    = 2'd1,
        MOD_STATUS  = 2'd2,
        MOD_CHANNEL = 2'd3
    } mod_t;

    state_t         state, state_n;
    logic [33:0]    cmd_r;
    mod_t           cmd_mod;
    logic [TW-1:0]  timer;
    logic           tmo_hit;
    logic           echo_pend, rx_pend;
    logic           cmd_err, tx_tmo, rx_ovr;
    logic           set_cmd_err, set_tx_tmo, set_rx_ovr;
    logic [31:0]    rx_buf;
    logic [7:0]     stat, last_status;
    logic           can_grant, gnt_rx, gnt_echo, gnt_stat;

    assign cmd_mod = mod_t'(cmd_r[33:32]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (!cmd_fifo_empty) state_n = DECODE;
            DECODE: begin
                case (cmd_mod)
                    MOD_CONFIG, MOD_CHANNEL: state_n = ECHO;
                    MOD_DATA:                state_n = TX;
                    default:                 state_n = IDLE;
                endcase
            end
            TX:     if (tx_ready || tmo_hit) state_n = IDLE;
            ECHO:   if (gnt_echo) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output/arbitration decode; the push strobe itself blocks the next grant.
    always_comb begin
        busy        = (state != IDLE);
        tmo_hit     = (TX_TIMEOUT != 0) && (timer == TW'(TX_TIMEOUT - 1));
        stat        = {sl_status, tx_tmo, rx_ovr, cmd_err};
        can_grant   = !rsp_fifo_full && !rsp_fifo_inc;
        gnt_rx      = can_grant && rx_pend;
        gnt_echo    = can_grant && !rx_pend && echo_pend;
        gnt_stat    = can_grant && !rx_pend && !echo_pend && (stat != last_status);
        set_cmd_err = (state == DECODE) && (cmd_mod == MOD_STATUS);
        set_tx_tmo  = (state == TX) && !tx_ready && tmo_hit;
        set_rx_ovr  = rx_strobe && rx_pend && !gnt_rx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r         <= '0;
            cmd_fifo_inc  <= 1'b0;
            config_out    <= '0;
            channel_out   <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            timer         <= '0;
            echo_pend     <= 1'b0;
            rx_pend       <= 1'b0;
            rx_buf        <= '0;
            cmd_err       <= 1'b0;
            tx_tmo        <= 1'b0;
            rx_ovr        <= 1'b0;
            last_status   <= '0;
            rsp_fifo_inc  <= 1'b0;
            rsp_fifo_data <= '0;
        end else begin
            cmd_fifo_inc <= 1'b0;
            if (state == IDLE && !cmd_fifo_empty) begin
                cmd_r        <= cmd_fifo_data;
                cmd_fifo_inc <= 1'b1;
            end

            if (state == DECODE) begin
                case (cmd_mod)
                    MOD_CONFIG: begin
                        config_out <= cmd_r[CONFIG_W-1:0];
                        echo_pend  <= 1'b1;
                    end
                    MOD_CHANNEL: begin
                        channel_out <= cmd_r[CHANNEL_W-1:0];
                        echo_pend   <= 1'b1;
                    end
                    MOD_DATA: begin
                        tx_data  <= cmd_r[31:0];
                        tx_valid <= 1'b1;
                        timer    <= '0;
                    end
                    default: ;
                endcase
            end

            if (state == TX) begin
                if (tx_ready || tmo_hit) tx_valid <= 1'b0;
                else                     timer    <= timer + TW'(1);
            end

            if (gnt_echo) echo_pend <= 1'b0;

            // Sticky flags clear when pushed, unless re-set on the same edge.
            cmd_err <= set_cmd_err | (cmd_err & ~gnt_stat);
            tx_tmo  <= set_tx_tmo  | (tx_tmo  & ~gnt_stat);
            rx_ovr  <= set_rx_ovr  | (rx_ovr  & ~gnt_stat);
            if (gnt_stat) last_status <= stat;

            if (rx_strobe && (!rx_pend || gnt_rx)) begin
                rx_buf  <= rx_data;
                rx_pend <= 1'b1;
            end else if (gnt_rx) begin
                rx_pend <= 1'b0;
            end

            rsp_fifo_inc <= gnt_rx | gnt_echo | gnt_stat;
            if (gnt_rx)
                rsp_fifo_data <= {2'd1, rx_buf};
            else if (gnt_echo)
                rsp_fifo_data <= (cmd_mod == MOD_CHANNEL) ? {2'd3, 32'(channel_out)}
                                                          : {2'd0, 32'(config_out)};
            else if (gnt_stat)
                rsp_fifo_data <= {2'd2, 24'd0, stat};
            else
                rsp_fifo_data <= '0;
        end
    end

endmodule

// File: tb/tb_sl_fifo_scheduler.sv
// Directed bench for sl_fifo_scheduler: one task per scenario, hand-computed
// expectations, response pushes captured by a negedge monitor.
module tb_sl_fifo_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_fifo_empty;
  logic [33:0] cmd_fifo_data;
  logic        cmd_fifo_inc;
  logic        rsp_fifo_full;
  logic [33:0] rsp_fifo_data;
  logic        rsp_fifo_inc;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_strobe;
  logic [4:0]  sl_status;
  logic [15:0] config_out;
  logic [1:0]  channel_out;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pops   = 0;
  logic [33:0] rq[$];
  int          rc[$];

  sl_fifo_scheduler #(.CONFIG_W(16), .CHANNEL_W(2), .TX_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_data(cmd_fifo_data), .cmd_fifo_inc(cmd_fifo_inc),
    .rsp_fifo_full(rsp_fifo_full), .rsp_fifo_data(rsp_fifo_data), .rsp_fifo_inc(rsp_fifo_inc),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .sl_status(sl_status),
    .config_out(config_out), .channel_out(channel_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_fifo_inc) begin
      rq.push_back(rsp_fifo_data);
      rc.push_back(cyc);
    end
    if (cmd_fifo_inc) pops++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [33:0] w, output bit ok);
    ok = 1'b0;
    cmd_fifo_data  = w;
    cmd_fifo_empty = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_fifo_inc) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_fifo_empty = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_fifo_empty = 1'b1; cmd_fifo_data = '0; rsp_fifo_full = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_strobe = 1'b0; sl_status = '0;
    wait_cyc(3);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_fifo_inc, rsp_fifo_inc, tx_valid, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000", {cmd_fifo_inc, rsp_fifo_inc, tx_valid, busy});
    end
    checks++;
    if (rsp_fifo_data !== 34'h0) begin
      errors++;
      $display("FAIL reset_rsp_data: got %h want 0", rsp_fifo_data);
    end
    checks++;
    if ({tx_data, config_out, channel_out} !== 50'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h want 0", {tx_data, config_out, channel_out});
    end
    wait_cyc(4);
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL reset_no_push: got %0d pushes want 0", rq.size());
    end
  endtask

  task automatic test_config;
    bit ok;
    rq.delete(); rc.delete(); pops = 0;
    send_cmd({2'd0, 32'h0000_A5C3}, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL config_pop: got no pop want pop");
    end
    checks++;
    if (config_out !== 16'h0) begin
      errors++;
      $display("FAIL config_early: got %h want 0000", config_out);
    end
    @(negedge clk);
    checks++;
    if (config_out !== 16'hA5C3) begin
      errors++;
      $display("FAIL config_out: got %h want a5c3", config_out);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL config_busy: got %b want 1", busy);
    end
    wait_cyc(5);
    checks++;
    if (rq.size() != 1 || rq[0] !== 34'h0_0000_A5C3) begin
      errors++;
      $display("FAIL config_echo: got %0d words first %h want 1 word 00000a5c3", rq.size(), rq[0]);
    end
    checks++;
    if (pops != 1) begin
      errors++;
      $display("FAIL config_pops: got %0d want 1", pops);
    end

    rq.delete(); rc.delete();
    send_cmd({2'd3, 32'hFFFF_FFFE}, ok);
    wait_cyc(6);
    checks++;
    if (channel_out !== 2'd2) begin
      errors++;
      $display("FAIL channel_out: got %0d want 2", channel_out);
    end
    checks++;
    if (config_out !== 16'hA5C3) begin
      errors++;
      $display("FAIL channel_keeps_config: got %h want a5c3", config_out);
    end
    checks++;
    if (rq.size() != 1 || rq[0] !== 34'h3_0000_0002) begin
      errors++;
      $display("FAIL channel_echo: got %0d words first %h want 1 word 300000002", rq.size(), rq[0]);
    end
  endtask

  task automatic test_tx;
    bit ok;
    int vcnt;
    rq.delete(); rc.delete();
    tx_ready = 1'b0;
    send_cmd({2'd1, 32'hDEAD_BEEF}, ok);
    vcnt = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_valid) vcnt++;
      checks++;
      if (tx_data !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL tx_data_held: got %h want deadbeef", tx_data);
      end
      if (i == 5) tx_ready = 1'b1;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tx_valid_drop: got %b want 0", tx_valid);
    end
    checks++;
    if (vcnt != 6) begin
      errors++;
      $display("FAIL tx_valid_cycles: got %0d want 6", vcnt);
    end
    wait_cyc(4);
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL tx_no_rsp: got %0d pushes want 0", rq.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle: got busy %b want 0", busy);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int vcnt;
    rq.delete(); rc.delete();
    tx_ready = 1'b0;
    send_cmd({2'd1, 32'h1234_5678}, ok);
    vcnt = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) vcnt++;
    end
    checks++;
    if (vcnt != 8) begin
      errors++;
      $display("FAIL tmo_valid_cycles: got %0d want 8", vcnt);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_valid_low: got %b want 0", tx_valid);
    end
    wait_cyc(6);
    checks++;
    if (rq.size() != 2 || rq[0] !== 34'h2_0000_0004 || rq[1] !== 34'h2_0000_0000) begin
      errors++;
      $display("FAIL tmo_status: got %0d words %h %h want 200000004 200000000", rq.size(), rq[0], rq[1]);
    end
    checks++;
    if (rc.size() == 2 && rc[1] - rc[0] != 2) begin
      errors++;
      $display("FAIL tmo_spacing: got %0d want 2", rc[1] - rc[0]);
    end
  endtask

  task automatic test_rx_overrun;
    rq.delete(); rc.delete();
    rsp_fifo_full = 1'b1;
    rx_data = 32'hCAFE_0001; rx_strobe = 1'b1;
    @(negedge clk);
    rx_data = 32'hCAFE_0002;
    @(negedge clk);
    rx_strobe = 1'b0; rx_data = '0;
    wait_cyc(4);
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL rx_full_hold: got %0d pushes want 0", rq.size());
    end
    rsp_fifo_full = 1'b0;
    wait_cyc(10);
    checks++;
    if (rq.size() != 3 || rq[0] !== 34'h1_CAFE_0001 || rq[1] !== 34'h2_0000_0002
        || rq[2] !== 34'h2_0000_0000) begin
      errors++;
      $display("FAIL rx_overrun: got %0d words %h %h %h want 1cafe0001 200000002 200000000",
               rq.size(), rq[0], rq[1], rq[2]);
    end
  endtask

  task automatic test_priority;
    bit ok;
    rq.delete(); rc.delete();
    rsp_fifo_full = 1'b1;
    send_cmd({2'd0, 32'h0000_1234}, ok);
    @(negedge clk);
    rx_data = 32'hBEEF_0005; rx_strobe = 1'b1; sl_status = 5'h01;
    @(negedge clk);
    rx_strobe = 1'b0; rx_data = '0;
    @(negedge clk);
    rsp_fifo_full = 1'b0;
    wait_cyc(10);
    checks++;
    if (rq.size() != 3 || rq[0] !== 34'h1_BEEF_0005 || rq[1] !== 34'h0_0000_1234
        || rq[2] !== 34'h2_0000_0008) begin
      errors++;
      $display("FAIL prio_order: got %0d words %h %h %h want 1beef0005 000001234 200000008",
               rq.size(), rq[0], rq[1], rq[2]);
    end
    checks++;
    if (rc.size() == 3 && (rc[1] - rc[0] != 2 || rc[2] - rc[1] != 2)) begin
      errors++;
      $display("FAIL prio_spacing: got %0d,%0d want 2,2", rc[1] - rc[0], rc[2] - rc[1]);
    end
    sl_status = 5'h00;
    wait_cyc(6);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: got busy %b want 0", busy);
    end
  endtask

  task automatic test_cmd_err_reset;
    bit ok;
    rq.delete(); rc.delete();
    send_cmd({2'd2, 32'h0000_0000}, ok);
    wait_cyc(8);
    checks++;
    if (rq.size() != 2 || rq[0] !== 34'h2_0000_0001 || rq[1] !== 34'h2_0000_0000) begin
      errors++;
      $display("FAIL cmd_err_status: got %0d words %h %h want 200000001 200000000", rq.size(), rq[0], rq[1]);
    end
    tx_ready = 1'b0;
    send_cmd({2'd1, 32'h5555_AAAA}, ok);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_tx_pre: got tx_valid %b want 1", tx_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_fifo_inc, rsp_fifo_inc, tx_valid, busy} !== 4'b0) begin
      errors++;
      $display("FAIL rst_in_tx_strobes: got %b want 0000", {cmd_fifo_inc, rsp_fifo_inc, tx_valid, busy});
    end
    checks++;
    if (tx_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_tx_data: got %h want 0", tx_data);
    end
    checks++;
    if (config_out !== 16'h0 || channel_out !== 2'd0) begin
      errors++;
      $display("FAIL rst_in_tx_regs: got %h/%0d want 0/0", config_out, channel_out);
    end
    checks++;
    if (rsp_fifo_data !== 34'h0) begin
      errors++;
      $display("FAIL rst_in_tx_rsp: got %h want 0", rsp_fifo_data);
    end
    rst = 1'b0;
    wait_cyc(3);
  endtask

  initial begin
    test_reset();
    test_config();
    test_tx();
    test_timeout();
    test_rx_overrun();
    test_priority();
    test_cmd_err_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
